alu_issue_stage: RTL and testbench

Decode/issue pipeline register sitting directly upstream of the ALU in the execute stage. It accepts one RV32I instruction per cycle together with its PC and register-file read data. It decodes the instruction into the 4-bit ALU control code and selects the A/B operands, then holds them in a valid/ready pipeline register for the ALU. Operands are forwarded from the single writeback port both at capture time and while the stage is stalled, so held operands never go stale.

---
 rtl/alu_issue_stage_if.sv | 45 ++++
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Issue-stage bus: upstream instruction offer, writeback snoop, flush,
// and the held ALU entry presented downstream.
interface alu_issue_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            wb_en;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            out_ready;
  logic            out_valid;
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] pc_out;
  logic [RA_W-1:0] rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic            jump;
  logic            illegal;

  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, wb_en, wb_rd, wb_data,
           flush, out_ready,
    input  in_ready, out_valid, alu_ctl, alu_a, alu_b, store_data, pc_out, rd,
           reg_write, mem_read, mem_write, branch, jump, illegal
  );

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, wb_en, wb_rd, wb_data,
           flush, out_ready,
    output in_ready, out_valid, alu_ctl, alu_a, alu_b, store_data, pc_out, rd,
           reg_write, mem_read, mem_write, branch, jump, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue register ahead of the ALU: decodes ALU control and
// operands, holds them under valid/ready, and keeps register operands fresh.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input logic              clk,
  input logic              rst,
  alu_issue_stage_if.slave bus
);
  localparam logic [3:0] CTL_AND = 4'd0,  CTL_OR   = 4'd1,  CTL_ADD  = 4'd2,
                         CTL_XOR = 4'd3,  CTL_SLL  = 4'd4,  CTL_SRL  = 4'd5,
                         CTL_SUB = 4'd6,  CTL_SLT  = 4'd7,  CTL_SGE  = 4'd8,
                         CTL_PA  = 4'd9,  CTL_PB   = 4'd10, CTL_EQ   = 4'd11,
                         CTL_NE  = 4'd12, CTL_SLTU = 4'd13, CTL_SGEU = 4'd14,
                         CTL_SRA = 4'd15;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_OPIMM = 7'b0010011,
                         OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111,
                         OPC_LOAD = 7'b0000011, OPC_STORE = 7'b0100011,
                         OPC_BRANCH = 7'b1100011, OPC_JAL = 7'b1101111,
                         OPC_JALR = 7'b1100111;

  typedef struct packed {
    logic            valid;
    logic [3:0]      ctl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sd;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rw;
    logic            mr;
    logic            mw;
    logic            br;
    logic            jp;
    logic            il;
    logic            a_rs1;   // alu_a came from rs1 and tracks writebacks
    logic            b_rs2;   // alu_b came from rs2
    logic            sd_rs2;  // store_data came from rs2
  } entry_t;

  entry_t q, d;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [RA_W-1:0] rs1f, rs2f, rdf;
  logic [XLEN-1:0] fwd1, fwd2, i_imm, s_imm, u_imm, shamt;
  logic            accept, consume;

  assign opcode = bus.instr[6:0];
  assign f3     = bus.instr[14:12];
  assign f7     = bus.instr[31:25];
  assign rdf    = RA_W'(bus.instr[11:7]);
  assign rs1f   = RA_W'(bus.instr[19:15]);
  assign rs2f   = RA_W'(bus.instr[24:20]);

  assign i_imm = XLEN'($signed(bus.instr[31:20]));
  assign s_imm = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
  assign u_imm = XLEN'({bus.instr[31:12], 12'h000});
  assign shamt = XLEN'(bus.instr[24:20]);

  // Capture-time bypass from the writeback port; x0 is never bypassed.
  assign fwd1 = (bus.wb_en && bus.wb_rd == rs1f && rs1f != '0) ? bus.wb_data : bus.rs1_data;
  assign fwd2 = (bus.wb_en && bus.wb_rd == rs2f && rs2f != '0) ? bus.wb_data : bus.rs2_data;

  assign bus.in_ready = !q.valid || bus.out_ready || bus.flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign consume      = q.valid && bus.out_ready;

  function automatic logic [3:0] arith_ctl(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000:  return alt ? CTL_SUB : CTL_ADD;
      3'b001:  return CTL_SLL;
      3'b010:  return CTL_SLT;
      3'b011:  return CTL_SLTU;
      3'b100:  return CTL_XOR;
      3'b101:  return alt ? CTL_SRA : CTL_SRL;
      3'b110:  return CTL_OR;
      default: return CTL_AND;
    endcase
  endfunction

  // Instruction decode into the next held entry.
  always_comb begin
    d       = '0;
    d.valid = 1'b1;
    d.pc    = bus.pc;
    d.rd    = rdf;
    d.rs1   = rs1f;
    d.rs2   = rs2f;
    case (opcode)
      OPC_OP: begin
        d.ctl = arith_ctl(f3, f7 == 7'h20);
        d.a = fwd1; d.a_rs1 = 1'b1;
        d.b = fwd2; d.b_rs2 = 1'b1;
        d.rw = 1'b1;
      end
      OPC_OPIMM: begin
        d.ctl = arith_ctl(f3, (f3 == 3'b101) && bus.instr[30]);
        d.a = fwd1; d.a_rs1 = 1'b1;
        d.b = (f3 == 3'b001 || f3 == 3'b101) ? shamt : i_imm;
        d.rw = 1'b1;
      end
      OPC_LUI: begin
        d.ctl = CTL_PB; d.b = u_imm; d.rw = 1'b1;
      end
      OPC_AUIPC: begin
        d.ctl = CTL_ADD; d.a = bus.pc; d.b = u_imm; d.rw = 1'b1;
      end
      OPC_LOAD: begin
        d.ctl = CTL_ADD; d.a = fwd1; d.a_rs1 = 1'b1; d.b = i_imm;
        d.mr = 1'b1; d.rw = 1'b1;
      end
      OPC_STORE: begin
        d.ctl = CTL_ADD; d.a = fwd1; d.a_rs1 = 1'b1; d.b = s_imm;
        d.sd = fwd2; d.sd_rs2 = 1'b1; d.mw = 1'b1; d.rd = '0;
      end
      OPC_BRANCH: begin
        d.rd = '0;
        d.a = fwd1; d.a_rs1 = 1'b1;
        d.b = fwd2; d.b_rs2 = 1'b1;
        d.br = 1'b1;
        case (f3)
          3'b000: d.ctl = CTL_EQ;
          3'b001: d.ctl = CTL_NE;
          3'b100: d.ctl = CTL_SLT;
          3'b101: d.ctl = CTL_SGE;
          3'b110: d.ctl = CTL_SLTU;
          3'b111: d.ctl = CTL_SGEU;
          default: begin
            d.ctl = CTL_PA; d.il = 1'b1; d.br = 1'b0;
            d.b = '0; d.b_rs2 = 1'b0;
          end
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        d.ctl = CTL_ADD; d.a = bus.pc; d.b = XLEN'(32'd4);
        d.jp = 1'b1; d.rw = 1'b1;
      end
      default: begin
        d.ctl = CTL_PA; d.a = fwd1; d.a_rs1 = 1'b1; d.il = 1'b1;
      end
    endcase
    if (rdf == '0) d.rw = 1'b0;
  end

  // Held entry: flush beats accept, accept beats drain, stall refreshes operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bus.flush) begin
      q.valid <= 1'b0;
    end else if (accept) begin
      q <= d;
    end else if (consume) begin
      q.valid <= 1'b0;
    end else if (q.valid && bus.wb_en && bus.wb_rd != '0) begin
      if (q.a_rs1  && bus.wb_rd == q.rs1) q.a  <= bus.wb_data;
      if (q.b_rs2  && bus.wb_rd == q.rs2) q.b  <= bus.wb_data;
      if (q.sd_rs2 && bus.wb_rd == q.rs2) q.sd <= bus.wb_data;
    end
  end

  assign bus.out_valid  = q.valid;
  assign bus.alu_ctl    = q.ctl;
  assign bus.alu_a      = q.a;
  assign bus.alu_b      = q.b;
  assign bus.store_data = q.sd;
  assign bus.pc_out     = q.pc;
  assign bus.rd         = q.rd;
  assign bus.reg_write  = q.rw;
  assign bus.mem_read   = q.mr;
  assign bus.mem_write  = q.mw;
  assign bus.branch     = q.br;
  assign bus.jump       = q.jp;
  assign bus.illegal    = q.il;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed instructions push expected
// entries, a negedge monitor pops and compares on every downstream transfer.
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_stage_if bus ();

  alu_issue_stage dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rw, mr, mw, br, jp, il;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t mk(input logic [3:0] ctl, input logic [31:0] a, b, sd, pc,
                              input logic [4:0] rd, input logic rw, mr, mw, br, jp, il);
    exp_t e;
    e.ctl = ctl; e.a = a; e.b = b; e.sd = sd; e.pc = pc; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.jp = jp; e.il = il;
    return e;
  endfunction

  function automatic exp_t sample();
    exp_t e;
    e.ctl = bus.alu_ctl; e.a = bus.alu_a; e.b = bus.alu_b; e.sd = bus.store_data;
    e.pc = bus.pc_out; e.rd = bus.rd; e.rw = bus.reg_write; e.mr = bus.mem_read;
    e.mw = bus.mem_write; e.br = bus.branch; e.jp = bus.jump; e.il = bus.illegal;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: every transfer downstream is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      exp_t act, e;
      act = sample();
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_transfer: got %h, expected no entry", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL transfer pc=%h: got %h, expected %h", e.pc, act, e);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [31:0] pcv, r1, r2,
                       input exp_t e, input bit push);
    bus.instr = ins; bus.pc = pcv; bus.rs1_data = r1; bus.rs2_data = r2;
    bus.in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 0; bus.instr = '0; bus.pc = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    bus.wb_en = 0; bus.wb_rd = '0; bus.wb_data = '0; bus.flush = 0; bus.out_ready = 0;

    repeat (2) @(posedge clk); #1;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_outputs", 32'(sample() != '0), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Streaming with out_ready held high.
    bus.out_ready = 1'b1;
    issue(32'h002081B3, 32'h100, 32'd5, 32'd7, mk(2, 5, 7, 0, 32'h100, 3, 1,0,0,0,0,0), 1);
    issue(32'h402081B3, 32'h104, 32'd5, 32'd7, mk(6, 5, 7, 0, 32'h104, 3, 1,0,0,0,0,0), 1);
    issue(32'h40335293, 32'h108, 32'hFFFFFF00, 32'd0,
          mk(15, 32'hFFFFFF00, 3, 0, 32'h108, 5, 1,0,0,0,0,0), 1);
    issue(32'h123450B7, 32'h10C, 32'd1, 32'd2,
          mk(10, 0, 32'h12345000, 0, 32'h10C, 1, 1,0,0,0,0,0), 1);
    issue(32'h00208063, 32'h110, 32'd3, 32'd3, mk(11, 3, 3, 0, 32'h110, 0, 0,0,0,1,0,0), 1);
    issue(32'h0000007F, 32'h114, 32'h11, 32'h22, mk(9, 32'h11, 0, 0, 32'h114, 0, 0,0,0,0,0,1), 1);
    issue(32'h0020A423, 32'h118, 32'h1000, 32'hAB,
          mk(2, 32'h1000, 8, 32'hAB, 32'h118, 0, 0,0,1,0,0,0), 1);
    issue(32'hFFC0A203, 32'h11C, 32'h2000, 32'd0,
          mk(2, 32'h2000, 32'hFFFFFFFC, 0, 32'h11C, 4, 1,1,0,0,0,0), 1);
    issue(32'h000000EF, 32'h400, 32'd0, 32'd0, mk(2, 32'h400, 4, 0, 32'h400, 1, 1,0,0,0,1,0), 1);
    issue(32'h00001397, 32'h800, 32'd0, 32'd0,
          mk(2, 32'h800, 32'h1000, 0, 32'h800, 7, 1,0,0,0,0,0), 1);
    issue(32'h00208033, 32'h120, 32'd1, 32'd2, mk(2, 1, 2, 0, 32'h120, 0, 0,0,0,0,0,0), 1);
    issue(32'h0020A063, 32'h124, 32'd9, 32'd8, mk(9, 9, 0, 0, 32'h124, 0, 0,0,0,0,0,1), 1);
    issue(32'hFFF00293, 32'h128, 32'h123, 32'd0,
          mk(2, 32'h123, 32'hFFFFFFFF, 0, 32'h128, 5, 1,0,0,0,0,0), 1);

    // Capture-time forwarding, then x0 must not forward.
    bus.wb_en = 1'b1; bus.wb_rd = 5'd1; bus.wb_data = 32'h99;
    issue(32'h002081B3, 32'h200, 32'd5, 32'd7, mk(2, 32'h99, 7, 0, 32'h200, 3, 1,0,0,0,0,0), 1);
    bus.wb_rd = 5'd0;
    issue(32'h002081B3, 32'h204, 32'd5, 32'd7, mk(2, 5, 7, 0, 32'h204, 3, 1,0,0,0,0,0), 1);
    bus.wb_en = 1'b0;
    @(posedge clk); #1;

    // Stall with refresh of both sources; a write to rd alone changes nothing.
    bus.out_ready = 1'b0;
    issue(32'h002081B3, 32'h300, 32'd5, 32'd7,
          mk(2, 32'h66, 32'h55, 0, 32'h300, 3, 1,0,0,0,0,0), 1);
    check("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
    bus.wb_en = 1'b1; bus.wb_rd = 5'd2; bus.wb_data = 32'h55;
    @(posedge clk); #1;
    check("refresh_alu_b", bus.alu_b, 32'h55);
    check("refresh_alu_a_unchanged", bus.alu_a, 32'd5);
    bus.wb_rd = 5'd1; bus.wb_data = 32'h66;
    @(posedge clk); #1;
    bus.wb_rd = 5'd3; bus.wb_data = 32'h77;
    @(posedge clk); #1;
    bus.wb_en = 1'b0;
    check("refresh_alu_a", bus.alu_a, 32'h66);
    check("stall_in_ready_held", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    issue(32'h402081B3, 32'h304, 32'd5, 32'd7, mk(6, 5, 7, 0, 32'h304, 3, 1,0,0,0,0,0), 1);
    check("no_bubble_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // Flush while holding, with a concurrent offer that must be dropped.
    bus.out_ready = 1'b0;
    issue(32'h002081B3, 32'h500, 32'd1, 32'd2, '0, 0);
    check("pre_flush_valid", 32'(bus.out_valid), 32'd1);
    bus.flush = 1'b1;
    issue(32'h402081B3, 32'h504, 32'd1, 32'd2, '0, 0);
    bus.flush = 1'b0;
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset during a stall, between clock edges.
    issue(32'h002081B3, 32'h600, 32'd1, 32'd2, '0, 0);
    check("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("async_reset_ctl", 32'(bus.alu_ctl), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
